// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that merges num_req requesters onto one FIFO write port and tracks FIFO occupancy.
// Latency: grant is combinational; w_en/data_in follow one cycle after the transfer. Backpressure: no grants while full.
module fifo_wr_arbiter #(
    parameter int data_width = 4,
    parameter int num_req    = 4,
    parameter int mem_width  = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [num_req-1:0]            req,
    input  logic [num_req*data_width-1:0] req_data,
    output logic [num_req-1:0]            gnt,
    output logic                          w_en,
    output logic [data_width-1:0]         data_in,
    input  logic                          r_pop,
    output logic [1:0]                    count,
    output logic                          mem_full,
    output logic                          underflow_err
);
    localparam int IDX_W = (num_req > 1) ? $clog2(num_req) : 1;
    localparam logic [1:0] FULL_CNT = 2'(mem_width);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(num_req - 1);

    logic [IDX_W-1:0]      last_q, win;
    logic [1:0]            count_q, count_d;
    logic                  full_q, err_q, err_d;
    logic                  w_en_q;
    logic [data_width-1:0] data_q;
    logic                  xfer;
    int                    idx;

    // Search starts just after the last winner and wraps; the first active requester wins.
    always_comb begin
        gnt  = '0;
        win  = last_q;
        xfer = 1'b0;
        idx  = 0;
        if (!rst && !full_q) begin
            for (int k = 1; k <= num_req; k++) begin
                idx = (int'(last_q) + k) % num_req;
                if (!xfer && req[idx]) begin
                    xfer     = 1'b1;
                    gnt[idx] = 1'b1;
                    win      = IDX_W'(idx);
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        if (r_pop && count_q == 2'd0)
            err_d = 1'b1;
        if (xfer && !r_pop)
            count_d = count_q + 2'd1;
        else if (!xfer && r_pop && count_q != 2'd0)
            count_d = count_q - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            w_en_q  <= 1'b0;
            data_q  <= '0;
            last_q  <= LAST_RST;
        end else begin
            count_q <= count_d;
            full_q  <= (count_d == FULL_CNT);
            err_q   <= err_d;
            w_en_q  <= xfer;
            if (xfer) begin
                data_q <= req_data[int'(win)*data_width +: data_width];
                last_q <= win;
            end
        end
    end

    assign w_en          = w_en_q;
    assign data_in       = data_q;
    assign count         = count_q;
    assign mem_full      = full_q;
    assign underflow_err = err_q;
endmodule
